// File: rtl/ex_result_stage_if.sv
// EX->MEM result channel: EX-side op/flags with valid/ready, MEM-side resolved head entry with valid/ready.
// The stage uses the slave modport; the producer/consumer environment uses the master modport.
interface ex_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5,
  parameter int RES_W = 3
);
  // EX side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zf;
  logic             alu_cf;
  logic             alu_of;
  logic [RES_W-1:0] ex_kind;
  logic [REG_W-1:0] ex_rd;
  logic             ex_wb_en;
  logic [WIDTH-1:0] ex_br_target;

  // MEM side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mem_y;
  logic [REG_W-1:0] mem_rd;
  logic             mem_wb_en;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             ov_exc;

  modport slave (
    input  in_valid, alu_y, alu_zf, alu_cf, alu_of, ex_kind, ex_rd, ex_wb_en, ex_br_target,
    input  out_ready,
    output in_ready,
    output out_valid, mem_y, mem_rd, mem_wb_en, br_taken, br_target, ov_exc
  );

  modport master (
    output in_valid, alu_y, alu_zf, alu_cf, alu_of, ex_kind, ex_rd, ex_wb_en, ex_br_target,
    output out_ready,
    input  in_ready,
    input  out_valid, mem_y, mem_rd, mem_wb_en, br_taken, br_target, ov_exc
  );
endinterface

// File: rtl/ex_result_stage.sv
// EX->MEM result stage: resolves branch/compare/trap results from ALU flags and buffers them
// in a 2-entry skid FIFO (head/tail registers) with valid/ready flow control and flush.
module ex_result_stage #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5,
  parameter int RES_W = 3
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  ex_result_stage_if.slave bus
);

  typedef enum logic [2:0] {
    K_PLAIN    = 3'd0,
    K_BEQ      = 3'd1,
    K_BNE      = 3'd2,
    K_SLT      = 3'd3,
    K_SLTU     = 3'd4,
    K_ADD_TRAP = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [REG_W-1:0] rd;
    logic             wb_en;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             exc;
  } entry_t;

  state_e r_state;
  entry_t r_head;
  entry_t r_tail;
  entry_t w_new;
  logic   w_push;
  logic   w_pop;

  // in_ready depends on occupancy only, so out_ready never reaches it combinationally.
  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign w_push        = bus.in_valid & bus.in_ready & ~flush;
  assign w_pop         = bus.out_valid & bus.out_ready;

  always_comb begin
    // NOTE: every field gets a default first so no path through the case infers a latch.
    w_new        = '0;
    w_new.y      = bus.alu_y;
    w_new.rd     = bus.ex_rd;
    w_new.wb_en  = bus.ex_wb_en;
    w_new.target = bus.ex_br_target;
    case (bus.ex_kind)
      RES_W'(K_BEQ): begin
        w_new.taken = bus.alu_zf;
        w_new.wb_en = 1'b0;
      end
      RES_W'(K_BNE): begin
        w_new.taken = ~bus.alu_zf;
        w_new.wb_en = 1'b0;
      end
      RES_W'(K_SLT):  w_new.y = {{(WIDTH-1){1'b0}}, bus.alu_y[WIDTH-1] ^ bus.alu_of};
      RES_W'(K_SLTU): w_new.y = {{(WIDTH-1){1'b0}}, bus.alu_cf};
      RES_W'(K_ADD_TRAP): begin
        w_new.exc   = bus.alu_of;
        w_new.wb_en = bus.ex_wb_en & ~bus.alu_of;
      end
      default: ;
    endcase
  end

  // Head is cleared whenever the FIFO drains so the data outputs read 0 while empty.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values (tail->head moves rely on it).
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head  <= w_new;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          case ({w_push, w_pop})
            2'b10: begin
              r_tail  <= w_new;
              r_state <= S_FULL;
            end
            2'b01: begin
              r_head  <= '0;
              r_state <= S_EMPTY;
            end
            2'b11:   r_head <= w_new;
            default: ;
          endcase
        end
        S_FULL: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_head  <= '0;
        end
      endcase
    end
  end

  assign bus.mem_y     = r_head.y;
  assign bus.mem_rd    = r_head.rd;
  assign bus.mem_wb_en = r_head.wb_en;
  assign bus.br_taken  = r_head.taken;
  assign bus.br_target = r_head.target;
  assign bus.ov_exc    = r_head.exc;

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: operands a/b are turned into ALU flags, and expected
// results come from plain signed/unsigned arithmetic on a/b, held in a FIFO queue model.
module tb_ex_result_stage;

  localparam int WIDTH = 32;
  localparam int REG_W = 5;
  localparam int RES_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [REG_W-1:0] rd;
    logic             wb;
    logic             taken;
    logic [WIDTH-1:0] target;
    logic             exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t model_q[$];

  ex_result_stage_if #(.WIDTH(WIDTH), .REG_W(REG_W), .RES_W(RES_W)) bus ();

  ex_result_stage #(.WIDTH(WIDTH), .REG_W(REG_W), .RES_W(RES_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Builds ALU flags for the op and the architecturally expected entry from a and b.
  function automatic void make_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic wb, input logic [31:0] tgt,
                                  output logic [31:0] y, output logic zf, output logic cf,
                                  output logic of, output exp_t e);
    logic [32:0] wide;
    longint      s;
    bit          is_sub;
    is_sub = (kind >= 1 && kind <= 4);
    if (is_sub) begin
      wide = {1'b0, a} - {1'b0, b};
      s    = longint'($signed(a)) - longint'($signed(b));
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s    = longint'($signed(a)) + longint'($signed(b));
    end
    y  = wide[31:0];
    cf = wide[32];
    zf = (y == 32'd0);
    of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e  = '{y: y, rd: rd, wb: wb, taken: 1'b0, target: tgt, exc: 1'b0};
    case (kind)
      1: begin e.taken = (a == b); e.wb = 1'b0; end
      2: begin e.taken = (a != b); e.wb = 1'b0; end
      3: e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: e.y = (a < b) ? 32'd1 : 32'd0;
      5: begin e.exc = of; e.wb = wb & ~of; end
      default: ;
    endcase
  endfunction

  task automatic check_outputs();
    exp_t h;
    h = (model_q.size() != 0) ? model_q[0] : '0;
    check("in_ready",  bus.in_ready,  model_q.size() < 2);
    check("out_valid", bus.out_valid, model_q.size() != 0);
    check("mem_y",     bus.mem_y,     h.y);
    check("mem_rd",    bus.mem_rd,    h.rd);
    check("mem_wb_en", bus.mem_wb_en, h.wb);
    check("br_taken",  bus.br_taken,  h.taken);
    check("br_target", bus.br_target, h.target);
    check("ov_exc",    bus.ov_exc,    h.exc);
  endtask

  // One clock: drive inputs, advance the model at the edge, check outputs 1 time unit later.
  task automatic cycle(input bit v, input bit rdy, input bit fl, input bit rs, input int kind,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic wb, input logic [31:0] tgt);
    logic [31:0] y;
    logic        zf, cf, of;
    exp_t        e;
    bit          do_push, do_pop;
    make_op(kind, a, b, rd, wb, tgt, y, zf, cf, of, e);
    bus.in_valid     = v;
    bus.out_ready    = rdy;
    bus.alu_y        = y;
    bus.alu_zf       = zf;
    bus.alu_cf       = cf;
    bus.alu_of       = of;
    bus.ex_kind      = RES_W'(kind);
    bus.ex_rd        = rd;
    bus.ex_wb_en     = wb;
    bus.ex_br_target = tgt;
    flush            = fl;
    rst              = rs;
    @(posedge clk);
    do_push = v && (model_q.size() < 2);
    do_pop  = rdy && (model_q.size() != 0);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input bit rdy);
    cycle(1'b0, rdy, 1'b0, 1'b0, 0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    flush = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    idle(1'b1);

    // PLAIN 2+3=5 into rd 3, then drains
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 32'd2, 32'd3, 5'd3, 1'b1, 32'd0);
    check("plain_y", bus.mem_y, 32'd5);
    idle(1'b1);
    check("plain_drained", bus.out_valid, 1'b0);

    // BEQ/BNE with equal operands (zf=1)
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1, 32'd7, 32'd7, 5'd4, 1'b1, 32'h40);
    check("beq_taken", bus.br_taken, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 2, 32'd7, 32'd7, 5'd4, 1'b1, 32'h80);
    check("bne_not_taken", bus.br_taken, 1'b0);

    // SLT with overflow, SLT -1, SLTU with borrow
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3, 32'd0, 32'h8000_0000, 5'd5, 1'b1, 32'd0);
    check("slt_of", bus.mem_y, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3, 32'd0, 32'd1, 5'd5, 1'b1, 32'd0);
    check("slt_neg", bus.mem_y, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4, 32'd1, 32'd2, 5'd5, 1'b1, 32'd0);
    check("sltu_borrow", bus.mem_y, 32'd1);

    // ADD_TRAP with and without overflow
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5, 32'h7FFF_FFFF, 32'd1, 5'd6, 1'b1, 32'd0);
    check("trap_exc", bus.ov_exc, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 5, 32'd1, 32'd2, 5'd6, 1'b1, 32'd0);
    check("trap_wb", bus.mem_wb_en, 1'b1);
    idle(1'b1);

    // Back-pressure: A,B fill, C held, then drain in order
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'hA, 32'd0, 5'd1, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'hB, 32'd0, 5'd2, 1'b1, 32'd0);
    check("full_in_ready", bus.in_ready, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'hC, 32'd0, 5'd3, 1'b1, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 32'hC, 32'd0, 5'd3, 1'b1, 32'd0);
    check("drain_b", bus.mem_y, 32'hB);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 32'hC, 32'd0, 5'd3, 1'b1, 32'd0);
    check("drain_c", bus.mem_y, 32'hC);
    idle(1'b1);
    idle(1'b1);

    // Flush while FULL with an incoming op
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h11, 32'd0, 5'd1, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h22, 32'd0, 5'd2, 1'b1, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h33, 32'd0, 5'd3, 1'b1, 32'd0);
    check("flush_empty", bus.out_valid, 1'b0);

    // Reset while FULL with an incoming op
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h44, 32'd0, 5'd1, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h55, 32'd0, 5'd2, 1'b1, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 32'h66, 32'd0, 5'd3, 1'b1, 32'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = pick_val();
      b = ($urandom_range(0, 5) == 0) ? a : pick_val();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            int'($urandom_range(0, 7)), a, b, 5'($urandom), 1'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
